// File: rtl/spi_rx_frontend.sv
// SPI mode-0 slave receiver feeding fib_table: synchronizes the raw pins into clk,
// deserializes MSB-first bytes and reports cs_n-delimited frame completion/errors.
module spi_rx_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_BYTES   = 41,
   parameter int BYTE_CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  RX_valid,
   output logic [7:0]            data_SPI_to_FIB,
   output logic                  frame_active,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic [BYTE_CNT_W-1:0] byte_count
);

   localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_BYTES);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_END} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d;
   logic                   sclk_s, cs_s, mosi_s, rise;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift_reg;
   logic [7:0]             rx_byte;
   logic                   pending;
   logic                   ovf;
   logic                   start, shift_en;

   // cs_n chain resets high so a reset never looks like a frame start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign rise   = sclk_s & ~sclk_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // cs_n deassertion wins over a coincident sclk rise
   always_comb begin
      state_nxt    = state;
      start        = 1'b0;
      shift_en     = 1'b0;
      frame_active = 1'b0;
      frame_done   = 1'b0;
      frame_error  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!cs_s) begin
               state_nxt = S_RECV;
               start     = 1'b1;
            end
         end
         S_RECV: begin
            frame_active = 1'b1;
            if (cs_s)      state_nxt = S_END;
            else if (rise) shift_en  = 1'b1;
         end
         S_END: begin
            if (bit_cnt == 3'd0 && !ovf) frame_done  = 1'b1;
            else                         frame_error = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A completed byte is parked in rx_byte and presented one clk later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt         <= '0;
         shift_reg       <= '0;
         rx_byte         <= '0;
         pending         <= 1'b0;
         ovf             <= 1'b0;
         RX_valid        <= 1'b0;
         data_SPI_to_FIB <= '0;
         byte_count      <= '0;
      end else begin
         RX_valid <= 1'b0;
         if (pending) begin
            RX_valid        <= 1'b1;
            data_SPI_to_FIB <= rx_byte;
            byte_count      <= byte_count + BYTE_CNT_W'(1);
            pending         <= 1'b0;
         end
         if (start) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_count <= '0;
            ovf        <= 1'b0;
         end else if (shift_en) begin
            shift_reg <= {shift_reg[6:0], mosi_s};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (byte_count < MAX_CNT) begin
                  rx_byte <= {shift_reg[6:0], mosi_s};
                  pending <= 1'b1;
               end else begin
                  ovf <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Directed bench for spi_rx_frontend: a frame-level model turns the transmitted bit
// list into expected bytes and frame outcomes, checked by a per-cycle monitor.
module tb_spi_rx_frontend;

   localparam int MAXB = 41;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       RX_valid;
   logic [7:0] data_SPI_to_FIB;
   logic       frame_active;
   logic       frame_done;
   logic       frame_error;
   logic [5:0] byte_count;

   spi_rx_frontend #(.SYNC_STAGES(2), .MAX_BYTES(MAXB), .BYTE_CNT_W(6)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .RX_valid(RX_valid), .data_SPI_to_FIB(data_SPI_to_FIB),
      .frame_active(frame_active), .frame_done(frame_done),
      .frame_error(frame_error), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int strobes = 0;
   int dones = 0;
   int errs = 0;
   bit prev_valid = 1'b0;

   bit       tx[$];
   bit [7:0] exp_bytes[$];
   bit       exp_err[$];
   int       exp_cnt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every strobe and every frame pulse is matched against the model queues
   always @(negedge clk) begin
      if (!rst) begin
         prev_valid = 1'b0;
      end else begin
         if (RX_valid) begin
            strobes++;
            chk("rx_not_back_to_back", {31'b0, prev_valid}, 32'd0);
            if (exp_bytes.size() == 0) chk("rx_unexpected_strobe", 32'd1, 32'd0);
            else chk("rx_byte", {24'b0, data_SPI_to_FIB}, {24'b0, exp_bytes.pop_front()});
         end
         prev_valid = RX_valid;
         if (frame_done || frame_error) begin
            if (frame_done) dones++;
            if (frame_error) errs++;
            chk("frame_pulse_exclusive", {31'b0, frame_done & frame_error}, 32'd0);
            if (exp_err.size() == 0) begin
               chk("frame_unexpected_pulse", 32'd1, 32'd0);
            end else begin
               chk("frame_error_kind", {31'b0, frame_error}, {31'b0, exp_err.pop_front()});
               chk("frame_byte_count", {26'b0, byte_count}, exp_cnt.pop_front());
            end
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic push_bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tx.push_back(v[i]);
   endtask

   // Model: frame outcome follows directly from the number of bits sent
   task automatic model_frame();
      int nb, nd;
      nb = tx.size() / 8;
      nd = (nb > MAXB) ? MAXB : nb;
      for (int b = 0; b < nd; b++) begin
         bit [7:0] v;
         for (int k = 0; k < 8; k++) v[7-k] = tx[8*b + k];
         exp_bytes.push_back(v);
      end
      exp_err.push_back((tx.size() % 8 != 0) || (nb > MAXB));
      exp_cnt.push_back(nd);
   endtask

   task automatic shift_bits(input int n);
      for (int i = 0; i < n; i++) begin
         mosi = tx[i];
         clks(4);
         sclk = 1'b1;
         clks(4);
         sclk = 1'b0;
      end
   endtask

   task automatic run_frame(input int gap);
      model_frame();
      cs_n = 1'b0;
      clks(4);
      shift_bits(tx.size());
      clks(4);
      cs_n = 1'b1;
      tx.delete();
      clks(gap);
   endtask

   task automatic check_drained(input string name);
      chk({name, "_bytes_left"}, exp_bytes.size(), 32'd0);
      chk({name, "_frames_left"}, exp_err.size(), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0, e0;
      bit saw_active;
      logic [7:0] held;

      clks(2);
      #1;
      chk("reset_outputs", {RX_valid, data_SPI_to_FIB, frame_active, frame_done, frame_error, byte_count}, 32'd0);
      rst = 1'b1;
      clks(4);

      // Interest packet
      s0 = strobes; d0 = dones; e0 = errs;
      push_bits(8'd112, 8);
      push_bits(8'h00, 8); push_bits(8'h00, 8); push_bits(8'hFF, 8); push_bits(8'hFF, 8);
      push_bits(8'h00, 8); push_bits(8'h00, 8); push_bits(8'hFF, 8); push_bits(8'hFF, 8);
      chk("model_first_byte", {24'b0, 8'd112}, 32'h70);
      run_frame(12);
      check_drained("interest");
      chk("interest_strobes", strobes - s0, 32'd9);
      chk("interest_done", dones - d0, 32'd1);
      chk("interest_no_error", errs - e0, 32'd0);
      chk("interest_byte_count", {26'b0, byte_count}, 32'd9);
      chk("interest_last_byte", {24'b0, data_SPI_to_FIB}, 32'hFF);

      // Partial byte
      s0 = strobes; d0 = dones; e0 = errs;
      push_bits(8'hA5, 8);
      push_bits(8'h16, 5);
      run_frame(12);
      check_drained("partial");
      chk("partial_strobes", strobes - s0, 32'd1);
      chk("partial_error", errs - e0, 32'd1);
      chk("partial_no_done", dones - d0, 32'd0);
      chk("partial_byte_count", {26'b0, byte_count}, 32'd1);
      chk("partial_data", {24'b0, data_SPI_to_FIB}, 32'hA5);

      // Overflow
      s0 = strobes; e0 = errs;
      for (int i = 0; i < 42; i++) push_bits(8'h3C, 8);
      run_frame(12);
      check_drained("overflow");
      chk("overflow_strobes", strobes - s0, 32'd41);
      chk("overflow_byte_count", {26'b0, byte_count}, 32'd41);
      chk("overflow_error", errs - e0, 32'd1);

      // Idle noise
      s0 = strobes; saw_active = 1'b0; held = data_SPI_to_FIB;
      mosi = 1'b1;
      for (int i = 0; i < 16; i++) begin
         sclk = ~sclk;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (frame_active) saw_active = 1'b1;
         end
      end
      clks(6);
      chk("noise_strobes", strobes - s0, 32'd0);
      chk("noise_frame_active", {31'b0, saw_active}, 32'd0);
      chk("noise_data_held", {24'b0, data_SPI_to_FIB}, {24'b0, held});

      // Reset mid-byte
      cs_n = 1'b0;
      clks(4);
      push_bits(8'hF0, 4);
      shift_bits(4);
      tx.delete();
      clks(2);
      rst = 1'b0;
      #1;
      chk("midbyte_reset_outputs", {RX_valid, data_SPI_to_FIB, frame_active, frame_done, frame_error, byte_count}, 32'd0);
      cs_n = 1'b1;
      clks(3);
      rst = 1'b1;
      clks(4);
      s0 = strobes; d0 = dones;
      push_bits(8'h12, 8);
      push_bits(8'h34, 8);
      run_frame(12);
      check_drained("after_reset");
      chk("after_reset_strobes", strobes - s0, 32'd2);
      chk("after_reset_done", dones - d0, 32'd1);
      chk("after_reset_byte_count", {26'b0, byte_count}, 32'd2);
      chk("after_reset_data", {24'b0, data_SPI_to_FIB}, 32'h34);

      // Back-to-back frames with a 4-clk cs_n gap
      d0 = dones;
      push_bits(8'h01, 8); push_bits(8'h02, 8); push_bits(8'h03, 8);
      run_frame(4);
      push_bits(8'h04, 8); push_bits(8'h05, 8);
      model_frame();
      cs_n = 1'b0;
      clks(4);
      #1;
      chk("b2b_count_restart", {26'b0, byte_count}, 32'd0);
      shift_bits(tx.size());
      clks(4);
      cs_n = 1'b1;
      tx.delete();
      clks(12);
      check_drained("b2b");
      chk("b2b_done_pulses", dones - d0, 32'd2);
      chk("b2b_byte_count", {26'b0, byte_count}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
